mem_port_arbiter: RTL and testbench

Arbitrates a single shared memory port between the pipeline's instruction-fetch requester and its data-memory requester. It sits between the pipelined CPU core and a unified instruction/data memory. It serialises accesses with a registered FSM, returns read data to the owning requester, and drives per-requester stall outputs for the hazard logic. Data accesses have priority, and a starvation counter guarantees forward progress for fetch.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: fetch vs data, data-priority with a
// starvation counter that guarantees fetch forward progress.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [2:0]        dm_ctrl,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_ctrl,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [3:0]          streak_q, streak_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic                if_ready_q, if_ready_d;
  logic                dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                dm_win;

  // Data wins unless fetch has waited out STARVE_MAX data grants.
  assign dm_win = dm_req & ~(if_req & (streak_q == SMAX));

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ctrl_d     = ctrl_q;
    if_ready_d = 1'b0;
    dm_ready_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (dm_win) begin
          state_d = BUSY_DM;
          we_d    = dm_we;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          ctrl_d  = dm_ctrl;
          if (!if_req)
            streak_d = 4'd0;
          else if (streak_q != SMAX)
            streak_d = streak_q + 4'd1;
        end else if (if_req) begin
          state_d  = BUSY_IF;
          we_d     = 1'b0;
          addr_d   = if_addr;
          wdata_d  = '0;
          ctrl_d   = 3'b000;
          streak_d = 4'd0;
        end
      end
      BUSY_IF: begin
        if (mem_ack) begin
          state_d    = RESP;
          if_rdata_d = mem_rdata;
          if_ready_d = 1'b1;
        end
      end
      BUSY_DM: begin
        if (mem_ack) begin
          state_d    = RESP;
          dm_rdata_d = mem_rdata;
          dm_ready_d = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      streak_q   <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ctrl_q     <= 3'b000;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ctrl_q     <= ctrl_d;
      if_ready_q <= if_ready_d;
      dm_ready_q <= dm_ready_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_valid = (state_q == BUSY_IF) | (state_q == BUSY_DM);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_ctrl  = ctrl_q;
  assign owner     = {state_q == BUSY_DM, state_q == BUSY_IF};
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_stall  = if_req & ~if_ready_q;
  assign dm_stall  = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk, reset;
  logic        if_req, if_ready, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ready, dm_stall;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [2:0]  dm_ctrl;
  logic        mem_valid, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_ctrl;
  logic [1:0]  owner;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ctrl(dm_ctrl), .dm_ready(dm_ready),
    .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ctrl(mem_ctrl), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b0; if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; dm_ctrl = 0; mem_rdata = 0;
    @(negedge clk); @(negedge clk);
    n_tests++; if (owner !== 2'b00) begin n_fail++;
      $display("FAIL rst_owner got %b exp 00", owner); end
    n_tests++; if (mem_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_valid got %b exp 0", mem_valid); end
    n_tests++; if ({mem_we, mem_addr, mem_wdata, mem_ctrl} !== '0) begin
      n_fail++; $display("FAIL rst_memfields got %h %h %h %h exp 0",
        mem_we, mem_addr, mem_wdata, mem_ctrl); end
    n_tests++; if ({if_ready, dm_ready} !== 2'b00) begin n_fail++;
      $display("FAIL rst_ready got %b%b exp 00", if_ready, dm_ready); end
    n_tests++; if ({if_rdata, dm_rdata} !== 64'h0) begin n_fail++;
      $display("FAIL rst_rdata got %h %h exp 0", if_rdata, dm_rdata); end
    reset = 1'b1;
  endtask

  task automatic test_single_load();
    dm_req = 1; dm_we = 0; dm_addr = 32'h100; dm_ctrl = 3'b010;
    #1;
    n_tests++; if (dm_stall !== 1'b1) begin n_fail++;
      $display("FAIL load_stall0 got %b exp 1", dm_stall); end
    @(negedge clk);
    n_tests++; if (mem_valid !== 1'b1 || mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL load_c1 got v=%b a=%h exp v=1 a=100",
        mem_valid, mem_addr); end
    n_tests++; if (owner !== 2'b10 || mem_ctrl !== 3'b010) begin n_fail++;
      $display("FAIL load_own got %b ctrl %b exp 10 010", owner, mem_ctrl); end
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    n_tests++; if (dm_ready !== 1'b1 || dm_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_c2 got r=%b d=%h exp 1 deadbeef",
        dm_ready, dm_rdata); end
    n_tests++; if (dm_stall !== 1'b0) begin n_fail++;
      $display("FAIL load_stall2 got %b exp 0", dm_stall); end
    mem_ack = 0; dm_req = 0;
    @(negedge clk);
    n_tests++; if (owner !== 2'b00 || dm_ready !== 1'b0) begin n_fail++;
      $display("FAIL load_c3 got own=%b r=%b exp 00 0", owner, dm_ready); end
  endtask

  task automatic test_wait_states();
    if_req = 1; if_addr = 32'h4;
    #1;
    n_tests++; if (if_stall !== 1'b1) begin n_fail++;
      $display("FAIL wait_stall0 got %b exp 1", if_stall); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_tests++;
      if (mem_valid !== 1 || mem_we !== 0 || mem_ctrl !== 3'b000 ||
          mem_addr !== 32'h4 || mem_wdata !== 0 || if_ready !== 0 ||
          if_stall !== 1) begin
        n_fail++; $display("FAIL wait_c%0d got v=%b we=%b c=%b a=%h r=%b s=%b",
          c, mem_valid, mem_we, mem_ctrl, mem_addr, if_ready, if_stall);
      end
      mem_ack = (c == 4); mem_rdata = (c == 4) ? 32'h00000013 : $urandom;
    end
    @(negedge clk);
    n_tests++; if (if_ready !== 1 || if_rdata !== 32'h13 || if_stall !== 0 ||
                   mem_valid !== 0) begin n_fail++;
      $display("FAIL wait_c5 got r=%b d=%h s=%b v=%b exp 1 13 0 0",
        if_ready, if_rdata, if_stall, mem_valid); end
    mem_ack = 0; if_req = 0;
    @(negedge clk);
    n_tests++; if (if_ready !== 1'b0) begin n_fail++;
      $display("FAIL wait_c6 got %b exp 0", if_ready); end
  endtask

  task automatic test_priority();
    if_req = 1; if_addr = 32'h8;
    dm_req = 1; dm_we = 1; dm_wdata = 32'h55; dm_addr = 32'h200;
    @(negedge clk);
    n_tests++; if (owner !== 2'b10 || mem_we !== 1 || mem_wdata !== 32'h55)
      begin n_fail++; $display("FAIL prio_c1 got own=%b we=%b wd=%h exp 10 1 55",
        owner, mem_we, mem_wdata); end
    mem_ack = 1;
    @(negedge clk);
    n_tests++; if (dm_ready !== 1 || if_stall !== 1) begin n_fail++;
      $display("FAIL prio_c2 got dr=%b is=%b exp 1 1", dm_ready, if_stall); end
    mem_ack = 0; dm_req = 0;
    @(negedge clk);
    n_tests++; if (owner !== 2'b00 || mem_valid !== 0) begin n_fail++;
      $display("FAIL prio_c3 got own=%b v=%b exp 00 0", owner, mem_valid); end
    @(negedge clk);
    n_tests++; if (owner !== 2'b01 || mem_addr !== 32'h8 || mem_we !== 0 ||
                   mem_wdata !== 0) begin n_fail++;
      $display("FAIL prio_c4 got own=%b a=%h we=%b wd=%h exp 01 8 0 0",
        owner, mem_addr, mem_we, mem_wdata); end
    mem_ack = 1; mem_rdata = 32'h0000ABCD;
    @(negedge clk);
    n_tests++; if (if_ready !== 1 || if_rdata !== 32'hABCD) begin n_fail++;
      $display("FAIL prio_c5 got r=%b d=%h exp 1 abcd", if_ready, if_rdata); end
    mem_ack = 0; if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int  g = 0;
    bit  prev_v = 0;
    bit  done = 0;
    logic [1:0] exp_o;
    if_req = 1; if_addr = 32'hC;
    dm_req = 1; dm_we = 0; dm_addr = 32'h400;
    for (int c = 0; c < 80 && !done; c++) begin
      if (mem_valid && !prev_v) begin
        exp_o = ((g % (SMAX + 1)) == SMAX) ? 2'b01 : 2'b10;
        n_tests++; if (owner !== exp_o) begin n_fail++;
          $display("FAIL starve_g%0d got %b exp %b", g, owner, exp_o); end
        g++;
      end
      if (g == 2 * (SMAX + 1) && if_ready) done = 1;
      prev_v = mem_valid;
      mem_ack = mem_valid; mem_rdata = $urandom;
      if (done) begin if_req = 0; dm_req = 0; mem_ack = 0; end
      else @(negedge clk);
    end
    n_tests++; if (!done) begin n_fail++;
      $display("FAIL starve_timeout got %0d grants exp %0d", g, 2*(SMAX+1)); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    @(negedge clk);
    n_tests++; if (mem_valid !== 1'b1) begin n_fail++;
      $display("FAIL rmid_c1 got v=%b exp 1", mem_valid); end
    reset = 0;
    @(negedge clk);
    n_tests++; if (mem_valid !== 0 || owner !== 2'b00 || dm_ready !== 0 ||
                   dm_rdata !== 0 || if_rdata !== 0) begin n_fail++;
      $display("FAIL rmid_c2 got v=%b o=%b r=%b dd=%h id=%h exp 0 00 0 0 0",
        mem_valid, owner, dm_ready, dm_rdata, if_rdata); end
    reset = 1; dm_addr = 32'h304;
    @(negedge clk);
    n_tests++; if (dm_ready !== 0 || mem_valid !== 1 || mem_addr !== 32'h304)
      begin n_fail++; $display("FAIL rmid_c3 got r=%b v=%b a=%h exp 0 1 304",
        dm_ready, mem_valid, mem_addr); end
    mem_ack = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    n_tests++; if (dm_ready !== 1 || dm_rdata !== 32'h12345678) begin
      n_fail++; $display("FAIL rmid_c4 got r=%b d=%h exp 1 12345678",
        dm_ready, dm_rdata); end
    mem_ack = 0; dm_req = 0;
    @(negedge clk);
  endtask

  task automatic test_stray_ack();
    mem_ack = 1;
    for (int c = 0; c < 4; c++) begin
      mem_rdata = $urandom;
      @(negedge clk);
      n_tests++;
      if (if_ready !== 0 || dm_ready !== 0 || mem_valid !== 0 ||
          owner !== 2'b00 || if_rdata !== 0 || dm_rdata !== 32'h12345678) begin
        n_fail++; $display("FAIL stray_c%0d got ir=%b dr=%b v=%b o=%b id=%h dd=%h",
          c, if_ready, dm_ready, mem_valid, owner, if_rdata, dm_rdata);
      end
    end
    mem_ack = 0;
  endtask

  task automatic test_random();
    int          m_busy, m_streak;
    bit          m_resp, m_ifr, m_dmr;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, m_ifd, m_dmd;
    logic [2:0]  m_ctrl;
    logic [1:0]  e_own;
    reset = 0; if_req = 0; dm_req = 0; mem_ack = 0;
    @(negedge clk);
    reset = 1;
    m_busy = 0; m_streak = 0; m_resp = 0; m_ifr = 0; m_dmr = 0;
    m_we = 0; m_addr = 0; m_wdata = 0; m_ctrl = 0; m_ifd = 0; m_dmd = 0;
    for (int c = 0; c < 3000; c++) begin
      e_own = (m_busy == 1) ? 2'b01 : (m_busy == 2) ? 2'b10 : 2'b00;
      n_tests++;
      if (owner !== e_own || mem_valid !== (m_busy != 0) ||
          if_ready !== m_ifr || dm_ready !== m_dmr) begin
        n_fail++; $display("FAIL rnd_ctl c%0d got o=%b v=%b ir=%b dr=%b exp %b %b %b %b",
          c, owner, mem_valid, if_ready, dm_ready, e_own, m_busy != 0, m_ifr, m_dmr);
      end
      n_tests++;
      if (mem_we !== m_we || mem_addr !== m_addr || mem_wdata !== m_wdata ||
          mem_ctrl !== m_ctrl || if_rdata !== m_ifd || dm_rdata !== m_dmd) begin
        n_fail++; $display("FAIL rnd_data c%0d got %b %h %h %b %h %h exp %b %h %h %b %h %h",
          c, mem_we, mem_addr, mem_wdata, mem_ctrl, if_rdata, dm_rdata,
          m_we, m_addr, m_wdata, m_ctrl, m_ifd, m_dmd);
      end
      if (if_req ? m_ifr : ($urandom_range(0, 3) == 0)) begin
        if_req = if_req ? 1'($urandom_range(0, 1)) : 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (dm_req ? m_dmr : ($urandom_range(0, 2) == 0)) begin
        dm_req = dm_req ? 1'($urandom_range(0, 1)) : 1'b1;
        dm_we = 1'($urandom_range(0, 1)); dm_addr = $urandom;
        dm_wdata = $urandom; dm_ctrl = 3'($urandom_range(0, 7));
      end
      mem_ack = ($urandom_range(0, 2) == 0); mem_rdata = $urandom;
      #1;
      n_tests++;
      if (if_stall !== (if_req & ~m_ifr) || dm_stall !== (dm_req & ~m_dmr)) begin
        n_fail++; $display("FAIL rnd_stall c%0d got %b %b exp %b %b",
          c, if_stall, dm_stall, if_req & ~m_ifr, dm_req & ~m_dmr);
      end
      m_ifr = 0; m_dmr = 0;
      if (m_busy != 0) begin
        if (mem_ack) begin
          if (m_busy == 1) begin m_ifd = mem_rdata; m_ifr = 1; end
          else begin m_dmd = mem_rdata; m_dmr = 1; end
          m_busy = 0; m_resp = 1;
        end
      end else if (m_resp) begin
        m_resp = 0;
      end else if (dm_req && !(if_req && m_streak == SMAX)) begin
        m_busy = 2;
        m_streak = if_req ? ((m_streak + 1 > SMAX) ? SMAX : m_streak + 1) : 0;
        m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_ctrl = dm_ctrl;
      end else if (if_req) begin
        m_busy = 1; m_streak = 0;
        m_we = 0; m_addr = if_addr; m_wdata = 0; m_ctrl = 0;
      end
      @(negedge clk);
    end
    if_req = 0; dm_req = 0; mem_ack = 0;
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_wait_states();
    test_priority();
    test_starvation();
    test_reset_mid();
    test_stray_ack();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
